br_pred_unit: RTL
=================

// Module: br_pred_unit
// PURPOSE
//  Parametrised branch resolution unit with an integrated bimodal predictor and direct-mapped BTB.
//  The fetch side reads a predicted taken/target for the current fetch PC.
//  The execute side resolves the branch, flags a mispredict and supplies the redirect PC.
//  It also trains the tables. Sits between the exec ALU and the fetch PC mux.
// PARAMETERS
//  XLEN     32  datapath / PC width
//  ENTRIES  64  predictor entries; power of two, >=2; IDX_W = clog2(ENTRIES)
// PORTS
//  clk             in   1     single clock, all state on rising edge
//  rst_n           in   1     asynchronous, active-low reset
//  f_pc            in   XLEN  fetch PC for lookup
//  f_pred_taken    out  1     predicted taken for f_pc
//  f_pred_target   out  XLEN  predicted target for f_pc (valid when f_pred_taken)
//  ex_valid        in   1     execute-stage instruction valid
//  br_sig          in   1     instruction is a branch/jump
//  br_op           in   3     BR_* opcode from parameters.vh
//  pc              in   XLEN  PC of executing instruction
//  imm             in   XLEN  branch/jump immediate
//  alu_out         in   XLEN  BEQ/BNE: rs1-rs2; BLT*/BGE*: SLT/SLTU result (1 = less); JAL/JALR: target sum
//  ex_pred_taken   in   1     prediction that travelled with this instruction
//  ex_pred_target  in   XLEN  predicted target that travelled with it
//  flush_pred      in   1     invalidate all BTB entries
//  new_pc          out  XLEN  resolved next PC
//  pc_plus4        out  XLEN  pc + 4
//  mispredict      out  1     redirect fetch to new_pc
// BEHAVIOUR
//  Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. State per entry: valid, tag, target, 2-bit counter.
//  Reset (async): all valid = 0; all counters = 2'b01 (weakly not-taken).
//  Reset: tags and targets = 0; stats counters = 0.
//  Lookup (combinational): hit = valid[i] && tag match.
//  Lookup outputs: f_pred_taken = hit && cnt[1]; f_pred_target = hit ? target : f_pc+4.
//  During reset both lookup outputs still follow the rule (valid = 0, so no hit).
//  Resolve (combinational):
//   - BEQ: taken = (alu_out == 0). BNE: taken = (alu_out != 0).
//   - BLT/BLTU: taken = alu_out[0]. BGE/BGEU: taken = !alu_out[0].
//   - Branch target = pc + imm.
//   - JAL: always taken, target = alu_out. JALR: always taken, target = alu_out & ~1.
//   - Unknown br_op, or br_sig = 0: not taken.
//  new_pc = taken ? target : pc+4 (mod 2^XLEN, wrap silently).
//  mispredict = ex_valid && br_sig && (taken != ex_pred_taken || (taken && target != ex_pred_target)).
//  A non-branch (br_sig = 0) never mispredicts.
//  Update (rising edge, when ex_valid && br_sig) at the index of pc:
//   - Hit, conditional: counter saturating +1 if taken, -1 if not (11 and 00 hold). If taken, target rewritten.
//   - Miss, taken: allocate/overwrite entry: valid = 1, tag, target; counter = 2'b10 (jumps: 2'b11).
//   - Miss, not taken: no write.
//   - Jumps on hit: counter = 2'b11, target rewritten.
//  Same-cycle lookup and update on one index: lookup returns pre-update contents (no bypass).
//  flush_pred: all valid cleared next edge; counters untouched.
//  flush_pred wins over a same-cycle update (the entry ends invalid).
//  Reset asserted mid-operation clears state immediately. The first edge after rst_n rises may update.
// CONFIGURATION
//  BR_PRED_STATS_EN defined: adds output ports stat_br (32) and stat_mispred (32).
//   - stat_br increments on each ex_valid && br_sig edge.
//   - stat_mispred increments on each mispredict edge.
//   - Both wrap at 2^32. Both reset to 0 asynchronously; flush_pred does not clear them.
//  BR_PRED_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset, f_pc=0x100 -> f_pred_taken=0, f_pred_target=0x104.
//  2. BEQ pc=0x100 imm=0x20 alu_out=0, ex_pred_taken=0 -> new_pc=0x120, mispredict=1.
//     Next cycle f_pc=0x100 -> f_pred_taken=1, f_pred_target=0x120.
//  3. Same BEQ not taken (alu_out=5) twice -> counter 10->01->00; f_pred_taken=0.
//     A third not-taken keeps counter at 00.
//  4. JALR alu_out=0x2003, prediction 0x2002 taken -> new_pc=0x2002, mispredict=0.
//     Entry counter = 11.
//  5. pc=0x100 and pc=0x100+4*ENTRIES alias on one index -> second allocation evicts first.
//     Lookup 0x100 then misses.
//  6. flush_pred together with a taken update -> entry invalid after the edge.
//     With BR_PRED_STATS_EN: stat_br=1, stat_mispred per mispredict.

Source files
------------

// File: rtl/br_pred_unit.sv
// Branch resolve unit with bimodal predictor and direct-mapped BTB.
// Optional BR_PRED_STATS_EN adds branch/mispredict counters.
module br_pred_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [XLEN-1:0] f_pred_target,
  input  logic            ex_valid,
  input  logic            br_sig,
  input  logic [2:0]      br_op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_out,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            flush_pred,
  output logic [XLEN-1:0] new_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            mispredict
`ifdef BR_PRED_STATS_EN
  ,
  output logic [31:0]     stat_br,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_JAL  = 3'b010;
  localparam logic [2:0] BR_JALR = 3'b011;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[XLEN-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign f_pred_taken  = f_hit && cnt_q[f_idx][1];
  assign f_pred_target = f_hit ? tgt_q[f_idx] : f_pc + XLEN'(4);

  logic            taken;
  logic [XLEN-1:0] target;
  logic            is_jump;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    taken  = 1'b0;
    target = pc + imm;
    unique case (br_op)
      BR_BEQ:  taken = (alu_out == '0);
      BR_BNE:  taken = (alu_out != '0);
      BR_BLT,
      BR_BLTU: taken = alu_out[0];
      BR_BGE,
      BR_BGEU: taken = !alu_out[0];
      BR_JAL: begin
        taken  = 1'b1;
        target = alu_out;
      end
      BR_JALR: begin
        taken  = 1'b1;
        target = {alu_out[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
    if (!br_sig) taken = 1'b0;
  end

  assign is_jump = (br_op == BR_JAL) || (br_op == BR_JALR);
  assign new_pc  = taken ? target : pc_plus4;

  assign mispredict = ex_valid && br_sig &&
    ((taken != ex_pred_taken) ||
     (taken && (target != ex_pred_target)));

  logic             upd;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  assign upd   = ex_valid && br_sig;
  assign u_idx = pc[IDX_W+1:2];
  assign u_tag = pc[XLEN-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else begin
      if (upd) begin
        if (u_hit) begin
          if (is_jump) begin
            cnt_q[u_idx] <= 2'b11;
            tgt_q[u_idx] <= target;
          end else if (taken) begin
            if (cnt_q[u_idx] != 2'b11)
              cnt_q[u_idx] <= cnt_q[u_idx] + 2'b01;
            tgt_q[u_idx] <= target;
          end else if (cnt_q[u_idx] != 2'b00) begin
            cnt_q[u_idx] <= cnt_q[u_idx] - 2'b01;
          end
        end else if (taken) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= target;
          cnt_q[u_idx]   <= is_jump ? 2'b11 : 2'b10;
        end
      end
      // flush overrides any allocation made on the same edge
      if (flush_pred) valid_q <= '0;
    end
  end

`ifdef BR_PRED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br      <= '0;
      stat_mispred <= '0;
    end else begin
      if (upd)        stat_br      <= stat_br + 32'd1;
      if (mispredict) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule
